// File: rtl/nios_pio_pkg.sv
// nios_pio_pkg: shared definitions for the Nios II PIO blocks.
// Holds the register map, the pulse FSM state type and the pulse
// length width, plus the reload helper used by the pulse timer.
package nios_pio_pkg;

   localparam int PLEN_W = 16;

   localparam logic [2:0] ADDR_DATA   = 3'd0;
   localparam logic [2:0] ADDR_PULSE  = 3'd1;
   localparam logic [2:0] ADDR_PLEN   = 3'd2;
   localparam logic [2:0] ADDR_OUTSET = 3'd4;
   localparam logic [2:0] ADDR_OUTCLR = 3'd5;

   localparam logic [PLEN_W-1:0] PLEN_ONE = PLEN_W'(1);

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } pulse_state_t;

   // A length of 0 behaves like 1; the counter runs from len-1 down to 0.
   function automatic logic [PLEN_W-1:0] reload_count(input logic [PLEN_W-1:0] len);
      return (len == '0) ? '0 : (len - PLEN_ONE);
   endfunction

endpackage

// File: rtl/nios_pio_pulse_timer.sv
// nios_pio_pulse_timer: one-shot pulse counter for the output PIO.
// trigger starts or restarts the pulse; expire is high during the last
// cycle of the pulse (never while a retrigger is being taken).
module nios_pio_pulse_timer
   import nios_pio_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              trigger,
   input  logic [PLEN_W-1:0] len,
   output logic              active,
   output logic              expire
);

   pulse_state_t      state;
   logic [PLEN_W-1:0] cnt;

   // A retrigger on the expiry cycle wins, so the pending bits stay high.
   assign expire = (state == ACTIVE) && (cnt == '0) && !trigger;

   // Pulse FSM: load on trigger, count down while active, return to idle at zero.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= IDLE;
         cnt    <= '0;
         active <= 1'b0;
      end else if (trigger) begin
         state  <= ACTIVE;
         cnt    <= reload_count(len);
         active <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               active <= 1'b0;
            end
            ACTIVE: begin
               if (cnt == '0) begin
                  state  <= IDLE;
                  active <= 1'b0;
               end else begin
                  cnt <= cnt - PLEN_ONE;
               end
            end
            default: begin
               state  <= IDLE;
               active <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/nios_out_pio.sv
// nios_out_pio: Avalon-MM output PIO with a hardware one-shot pulse generator.
// Registers: DATA (0), PULSE mask (1), PLEN (2); readback has 1-cycle latency.
// Optional macro NIOS_OUT_PIO_SETCLR_EN adds OUTSET (4) and OUTCLR (5).
module nios_out_pio
   import nios_pio_pkg::*;
#(
   parameter int          DATA_W    = 8,
   parameter logic [31:0] RESET_VAL = 32'd0,
   parameter int          PULSE_LEN = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [2:0]        address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   output logic [DATA_W-1:0] out_port
);

   logic              wr;
   logic              wr_data;
   logic              wr_pulse;
   logic              wr_plen;
   logic              set_en;
   logic              clr_en;
   logic              trigger;
   logic              expire;
   logic              pulse_active;
   logic              unused_sink;
   logic [DATA_W-1:0] wmask;
   logic [DATA_W-1:0] data_r;
   logic [DATA_W-1:0] data_next;
   logic [DATA_W-1:0] pmask;
   logic [PLEN_W-1:0] plen;
   logic [31:0]       rd_mux;

   assign wr       = chipselect & ~write_n;
   assign wr_data  = wr && (address == ADDR_DATA);
   assign wr_pulse = wr && (address == ADDR_PULSE);
   assign wr_plen  = wr && (address == ADDR_PLEN);
   assign wmask    = writedata[DATA_W-1:0];
   assign trigger  = wr_pulse && (wmask != '0);
   assign out_port = data_r;

   // The upper writedata bits and the timer's active flag are not needed here.
   assign unused_sink = ^{writedata, pulse_active};

`ifdef NIOS_OUT_PIO_SETCLR_EN
   assign set_en = wr && (address == ADDR_OUTSET);
   assign clr_en = wr && (address == ADDR_OUTCLR);
`else
   assign set_en = 1'b0;
   assign clr_en = 1'b0;
`endif

   nios_pio_pulse_timer u_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .trigger (trigger),
      .len     (plen),
      .active  (pulse_active),
      .expire  (expire)
   );

   // Next DATA value: software writes first, then the pulse expiry clear on top.
   always_comb begin
      data_next = data_r;
      if (wr_data) data_next = wmask;
      if (set_en)  data_next = data_next | wmask;
      if (clr_en)  data_next = data_next & ~wmask;
      if (trigger) data_next = data_next | wmask;
      if (expire)  data_next = data_next & ~pmask;
   end

   // Register file: DATA, pending pulse mask and pulse length.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_r <= RESET_VAL[DATA_W-1:0];
         pmask  <= '0;
         plen   <= PLEN_W'(PULSE_LEN);
      end else begin
         data_r <= data_next;
         if (trigger) begin
            pmask <= pmask | wmask;
         end else if (expire) begin
            pmask <= '0;
         end
         if (wr_plen) plen <= writedata[PLEN_W-1:0];
      end
   end

   // Read mux decodes address every cycle without chipselect; unmapped reads are 0.
   always_comb begin
      rd_mux = '0;
      case (address)
         ADDR_DATA:  rd_mux = 32'(data_r);
         ADDR_PULSE: rd_mux = 32'(pmask);
         ADDR_PLEN:  rd_mux = 32'(plen);
         default:    rd_mux = '0;
      endcase
   end

   // Registered readback gives the 1-cycle read latency.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         readdata <= '0;
      end else begin
         readdata <= rd_mux;
      end
   end

endmodule

// File: tb/tb_nios_out_pio.sv
// tb_nios_out_pio: scoreboard bench for nios_out_pio (DATA_W=8, RESET_VAL=A5).
// Stimulus queues expected values tagged with a cycle number; the monitor
// compares them on the falling edge of that cycle.
module tb_nios_out_pio;

   localparam int SEL_OUT = 0;
   localparam int SEL_RD  = 1;

   logic        clk;
   logic        reset_n;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [7:0]  out_port;

   typedef struct {
      int          cyc;
      int          sel;
      logic [31:0] exp;
      string       name;
   } sb_item_t;

   sb_item_t sb[$];
   int       cyc;
   int       nChecks;
   int       nPass;

   nios_out_pio #(
      .DATA_W    (8),
      .RESET_VAL (32'hA5),
      .PULSE_LEN (16)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .out_port   (out_port)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Cycle index: number of rising edges seen so far.
   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compare every scoreboard entry due in this cycle.
   always @(negedge clk) begin
      logic [31:0] act;
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc == cyc) begin
            act = (sb[i].sel == SEL_OUT) ? {24'd0, out_port} : readdata;
            nChecks++;
            if (act === sb[i].exp) begin
               nPass++;
            end else begin
               $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)",
                        sb[i].name, act, sb[i].exp, cyc);
            end
            sb.delete(i);
         end
      end
   end

   // Queue an expected value for the falling edge 'offset' cycles from now.
   task automatic checkOutput(input int offset, input int sel,
                              input logic [31:0] exp, input string name);
      sb_item_t it;
      it.cyc  = cyc + offset;
      it.sel  = sel;
      it.exp  = exp;
      it.name = name;
      sb.push_back(it);
   endtask

   // One register write; returns just after the edge that samples it.
   task automatic applyStimulus(input logic [2:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(posedge clk);
      #1;
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      nChecks    = 0;
      nPass      = 0;
      reset_n    = 1'b0;
      address    = 3'd2;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;

      // Reset values, then PLEN readback one cycle after release.
      tick(2);
      reset_n = 1'b1;
      checkOutput(0, SEL_OUT, 32'hA5, "reset_out_port");
      checkOutput(0, SEL_RD,  32'h00, "reset_readdata");
      checkOutput(1, SEL_RD,  32'd16, "reset_plen_read");
      tick(2);

      // Plain DATA write and readback.
      applyStimulus(3'd0, 32'hFFFF_FF3C);
      checkOutput(0, SEL_OUT, 32'h3C, "data_write_out");
      checkOutput(1, SEL_RD,  32'h3C, "data_readback");
      tick(2);

      // PLEN=4 pulse on bit 0, watching PMASK readback.
      applyStimulus(3'd2, 32'd4);
      applyStimulus(3'd0, 32'h0);
      applyStimulus(3'd1, 32'h01);
      for (int k = 0; k < 4; k++) checkOutput(k, SEL_OUT, 32'h01, "pulse4_high");
      checkOutput(4, SEL_OUT, 32'h00, "pulse4_drop");
      for (int k = 1; k < 5; k++) checkOutput(k, SEL_RD, 32'h01, "pulse4_pmask");
      checkOutput(5, SEL_RD, 32'h00, "pulse4_pmask_clear");
      tick(7);

      // PLEN=10 pulse on bit 0, retrigger with bit 1 five cycles later.
      applyStimulus(3'd2, 32'd10);
      applyStimulus(3'd1, 32'h01);
      checkOutput(0, SEL_OUT, 32'h01, "retrig_first");
      checkOutput(4, SEL_OUT, 32'h01, "retrig_before");
      tick(4);
      applyStimulus(3'd1, 32'h02);
      for (int k = 0; k < 10; k++) checkOutput(k, SEL_OUT, 32'h03, "retrig_both");
      checkOutput(10, SEL_OUT, 32'h00, "retrig_drop");
      tick(12);

      // PLEN=0 acts as one cycle; reserved addresses are inert.
      applyStimulus(3'd2, 32'd0);
      applyStimulus(3'd1, 32'h80);
      checkOutput(0, SEL_OUT, 32'h80, "plen0_high");
      checkOutput(1, SEL_OUT, 32'h00, "plen0_drop");
      tick(2);
      address = 3'd2;
      checkOutput(1, SEL_RD, 32'h00, "plen0_readback");
      tick(1);
      applyStimulus(3'd3, 32'hFF);
      checkOutput(0, SEL_OUT, 32'h00, "addr3_ignored");
      checkOutput(1, SEL_RD,  32'h00, "addr3_reads0");
      tick(1);
      applyStimulus(3'd7, 32'hFF);
      checkOutput(0, SEL_OUT, 32'h00, "addr7_ignored");
      checkOutput(1, SEL_RD,  32'h00, "addr7_reads0");
      tick(2);

      // Expiry on the same edge as a DATA write: pulsed bit still drops.
      applyStimulus(3'd2, 32'd3);
      applyStimulus(3'd0, 32'h00);
      applyStimulus(3'd1, 32'h01);
      tick(2);
      applyStimulus(3'd0, 32'hFF);
      checkOutput(0, SEL_OUT, 32'hFE, "expire_vs_data");
      tick(2);

      // Expiry on the same edge as a PULSE write: treated as retrigger.
      applyStimulus(3'd0, 32'h00);
      applyStimulus(3'd1, 32'h01);
      tick(2);
      applyStimulus(3'd1, 32'h02);
      for (int k = 0; k < 3; k++) checkOutput(k, SEL_OUT, 32'h03, "expire_vs_pulse");
      checkOutput(3, SEL_OUT, 32'h00, "expire_vs_pulse_drop");
      tick(5);

      // Set/clear registers (inert without the option).
      applyStimulus(3'd0, 32'hF0);
      applyStimulus(3'd4, 32'h0F);
`ifdef NIOS_OUT_PIO_SETCLR_EN
      checkOutput(0, SEL_OUT, 32'hFF, "outset");
`else
      checkOutput(0, SEL_OUT, 32'hF0, "outset_disabled");
`endif
      checkOutput(1, SEL_RD, 32'h00, "outset_reads0");
      tick(1);
      applyStimulus(3'd5, 32'h81);
`ifdef NIOS_OUT_PIO_SETCLR_EN
      checkOutput(0, SEL_OUT, 32'h7E, "outclr");
`else
      checkOutput(0, SEL_OUT, 32'hF0, "outclr_disabled");
`endif
      checkOutput(1, SEL_RD, 32'h00, "outclr_reads0");
      tick(2);

      // Reset mid-pulse: immediate return to reset values, no residual pulse.
      applyStimulus(3'd2, 32'h20);
      applyStimulus(3'd1, 32'h0F);
      tick(2);
      reset_n = 1'b0;
      checkOutput(0, SEL_OUT, 32'hA5, "async_reset_out");
      checkOutput(0, SEL_RD,  32'h00, "async_reset_rd");
      tick(2);
      reset_n = 1'b1;
      address = 3'd1;
      checkOutput(1, SEL_RD,  32'h00, "post_reset_pmask");
      checkOutput(3, SEL_OUT, 32'hA5, "post_reset_out");
      tick(1);
      address = 3'd2;
      checkOutput(1, SEL_RD,  32'd16, "post_reset_plen");
      tick(4);

      // Any entry never reached by the monitor counts as a failure.
      if (sb.size() != 0) begin
         $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
         nChecks = nChecks + sb.size();
      end
      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
